// File: rtl/neuro_cmd_sequencer.sv
// Host command sequencer: parses OPC/LEN/payload frames from the UART byte stream,
// fills the weight/input buffers, launches MAC runs and publishes clamped results.
module neuro_cmd_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int ACC_W   = 20,
  parameter int TIMEOUT = 50000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_error,
  input  logic             i_mac_done,
  input  logic [ACC_W-1:0] i_mac_result,
  output logic             o_buf_we,
  output logic             o_buf_sel,
  output logic [AW-1:0]    o_buf_addr,
  output logic [7:0]       o_buf_wdata,
  output logic             o_mac_start,
  output logic [AW:0]      o_mac_len,
  output logic [7:0]       o_res_data,
  output logic             o_res_valid,
  output logic [7:0]       o_status
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [7:0] OPC_W = 8'h57;
  localparam logic [7:0] OPC_I = 8'h49;
  localparam logic [7:0] OPC_R = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_RUN  = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_sel_in;
  logic            r_is_run;
  logic [AW:0]     r_len;
  logic [AW-1:0]   r_idx;
  logic [TW-1:0]   r_tmo;
  logic [3:0]      r_err;
  logic            r_buf_we;
  logic            r_buf_sel;
  logic [AW-1:0]   r_buf_addr;
  logic [7:0]      r_buf_wdata;
  logic            r_mac_start;
  logic [AW:0]     r_mac_len;
  logic [7:0]      r_res_data;
  logic            r_res_valid;

  logic            w_is_opc;
  logic            w_len_ok;
  logic            w_last;
  logic            w_tmo_hit;
  logic [7:0]      w_clamp;

  always_comb begin
    w_is_opc  = (i_rx_data == OPC_W) || (i_rx_data == OPC_I) || (i_rx_data == OPC_R);
    w_len_ok  = (i_rx_data != 8'd0) && (i_rx_data <= 8'(DEPTH));
    w_last    = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));
    w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));
    // Negative results saturate to 0, anything above 255 to 255.
    if (i_mac_result[ACC_W-1])
      w_clamp = 8'd0;
    else if (|i_mac_result[ACC_W-2:8])
      w_clamp = 8'hFF;
    else
      w_clamp = i_mac_result[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_sel_in    <= 1'b0;
      r_is_run    <= 1'b0;
      r_len       <= '0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_err       <= 4'd0;
      r_buf_we    <= 1'b0;
      r_buf_sel   <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_wdata <= 8'd0;
      r_mac_start <= 1'b0;
      r_mac_len   <= '0;
      r_res_data  <= 8'd0;
      r_res_valid <= 1'b0;
    end else begin
      r_buf_we    <= 1'b0;
      r_mac_start <= 1'b0;
      r_res_valid <= 1'b0;
      // A framing error overrides any byte delivered in the same cycle.
      if (i_rx_error) begin
        r_err   <= 4'd4;
        r_state <= S_IDLE;
        r_tmo   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_rx_valid) begin
              if (w_is_opc) begin
                r_sel_in <= (i_rx_data == OPC_I);
                r_is_run <= (i_rx_data == OPC_R);
                r_tmo    <= '0;
                r_state  <= S_LEN;
              end else begin
                r_err <= 4'd1;
              end
            end
          end
          S_LEN: begin
            if (i_rx_valid) begin
              r_tmo <= '0;
              if (w_len_ok) begin
                r_len   <= i_rx_data[AW:0];
                r_idx   <= '0;
                r_state <= r_is_run ? S_RUN : S_DATA;
              end else begin
                r_err   <= 4'd2;
                r_state <= S_IDLE;
              end
            end else if (w_tmo_hit) begin
              r_err   <= 4'd3;
              r_state <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          S_DATA: begin
            if (i_rx_valid) begin
              r_tmo       <= '0;
              r_buf_we    <= 1'b1;
              r_buf_sel   <= r_sel_in;
              r_buf_addr  <= r_idx;
              r_buf_wdata <= i_rx_data;
              r_idx       <= r_idx + AW'(1);
              if (w_last)
                r_state <= S_IDLE;
            end else if (w_tmo_hit) begin
              r_err   <= 4'd3;
              r_state <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          S_RUN: begin
            r_mac_start <= 1'b1;
            r_mac_len   <= r_len;
            r_state     <= S_WAIT;
            if (i_rx_valid)
              r_err <= 4'd5;
          end
          S_WAIT: begin
            if (i_rx_valid)
              r_err <= 4'd5;
            if (i_mac_done) begin
              r_res_data  <= w_clamp;
              r_res_valid <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_buf_we    = r_buf_we;
  assign o_buf_sel   = r_buf_sel;
  assign o_buf_addr  = r_buf_addr;
  assign o_buf_wdata = r_buf_wdata;
  assign o_mac_start = r_mac_start;
  assign o_mac_len   = r_mac_len;
  assign o_res_data  = r_res_data;
  assign o_res_valid = r_res_valid;
  assign o_status    = {r_err, (r_state != S_IDLE), r_state};

endmodule
